// File: rtl/addsub_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package addsub_pkg;

    // Slice width processed per RUN cycle.
    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_adder.sv
// 4-bit carry-lookahead slice adder; also exposes the carry into its MSB
// so the sequencer can derive signed overflow on the top slice.
module nibble_adder
    import addsub_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [NIB_W-1:0] w_g;
    logic [NIB_W-1:0] w_p;
    logic [NIB_W:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Lookahead carries, each expanded directly from generate/propagate terms.
    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

    assign sum      = w_p ^ w_c[NIB_W-1:0];
    assign cout     = w_c[NIB_W];
    assign c_msb_in = w_c[NIB_W-1];

endmodule

// File: rtl/addsub_nibble_sequencer.sv
// Nibble-serial adder/subtractor: accepts an operand pair in IDLE, processes
// one 4-bit slice per cycle LSB first in RUN, and holds the result in DONE
// until the consumer takes it.
module addsub_nibble_sequencer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NIB_W  = addsub_pkg::NIB_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              cout,
    output logic              overflow,
    output logic              busy
);

    import addsub_pkg::state_t;
    import addsub_pkg::IDLE;
    import addsub_pkg::RUN;
    import addsub_pkg::DONE;

    localparam int unsigned NSLICE = DATA_W / NIB_W;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_result;
    logic              r_carry;
    logic [IDX_W-1:0]  r_idx;
    logic              r_cout;
    logic              r_overflow;

    logic [NIB_W-1:0]  w_a_nib;
    logic [NIB_W-1:0]  w_b_nib;
    logic [NIB_W-1:0]  w_sum;
    logic              w_cout;
    logic              w_c_msb_in;
    logic              w_accept;
    logic              w_last;
    logic              w_take;

    assign w_accept = in_valid & r_in_ready;
    assign w_take   = r_out_valid & out_ready;
    assign w_last   = (r_idx == LAST_IDX);

    // Select the operand slice addressed by the current index.
    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int unsigned j = 0; j < NSLICE; j++) begin
            if (r_idx == IDX_W'(j)) begin
                w_a_nib = r_a[j*NIB_W +: NIB_W];
                w_b_nib = r_b[j*NIB_W +: NIB_W];
            end
        end
    end

    nibble_adder u_nibble_adder (
        .a        (w_a_nib),
        .b        (w_b_nib),
        .cin      (r_carry),
        .sum      (w_sum),
        .cout     (w_cout),
        .c_msb_in (w_c_msb_in)
    );

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_nxt = RUN;
            RUN:     if (w_last)   w_state_nxt = DONE;
            DONE:    if (w_take)   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register and handshake/status flags registered from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    // Operand capture, slice-by-slice accumulation and final flag update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= op_a;
                        r_b     <= op_b ^ {DATA_W{mode}};
                        r_carry <= mode;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    for (int unsigned j = 0; j < NSLICE; j++) begin
                        if (r_idx == IDX_W'(j)) begin
                            r_result[j*NIB_W +: NIB_W] <= w_sum;
                        end
                    end
                    r_carry <= w_cout;
                    if (w_last) begin
                        r_cout     <= w_cout;
                        r_overflow <= w_c_msb_in ^ w_cout;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (w_take) begin
                        r_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign result    = r_result;
    assign cout      = r_cout;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_addsub_nibble_sequencer.sv
// Self-checking bench for addsub_nibble_sequencer (DATA_W = 16).
module tb_addsub_nibble_sequencer;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned LAT    = DATA_W / 4;

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic              co;
        logic              ov;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              cout;
    logic              overflow;
    logic              busy;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    addsub_nibble_sequencer #(.DATA_W(DATA_W), .NIB_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference arithmetic on full-width integers.
    function automatic exp_t model(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                   input logic m);
        logic [DATA_W:0] full;
        exp_t            e;
        if (!m) full = {1'b0, a} + {1'b0, b};
        else    full = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1);
        e.res = full[DATA_W-1:0];
        e.co  = full[DATA_W];
        if (!m) e.ov = (a[DATA_W-1] == b[DATA_W-1]) && (e.res[DATA_W-1] != a[DATA_W-1]);
        else    e.ov = (a[DATA_W-1] != b[DATA_W-1]) && (e.res[DATA_W-1] != a[DATA_W-1]);
        return e;
    endfunction

    function automatic exp_t mk(input logic [DATA_W-1:0] r, input logic c, input logic o);
        exp_t e;
        e.res = r;
        e.co  = c;
        e.ov  = o;
        return e;
    endfunction

    // Offer one operand pair, wait for acceptance, queue its expected result.
    task automatic send_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                           input logic m, input exp_t e);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        op_a = a; op_b = b; mode = m; in_valid = 1'b1;
        @(posedge clk); #1;
        sb.push_back(e);
        in_valid = 1'b0;
        op_a = DATA_W'($urandom);
        op_b = DATA_W'($urandom);
        mode = 1'($urandom_range(0, 1));
    endtask

    // Count edges until out_valid, bounded.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; op_a = 16'h1234; op_b = 16'h4321; mode = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL reset_result: got %h want 0000", result); end
        n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b want 0", cout); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_arith_table;
        logic [DATA_W-1:0] ta [5];
        logic [DATA_W-1:0] tb [5];
        logic              tm [5];
        exp_t              te [5];
        exp_t              e;
        int                lat;
        ta = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000};
        tb = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
        tm = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        te[0] = mk(16'h0001, 1'b0, 1'b0);
        te[1] = mk(16'hFFFE, 1'b1, 1'b0);
        te[2] = mk(16'h8000, 1'b0, 1'b1);
        te[3] = mk(16'h7FFF, 1'b1, 1'b1);
        te[4] = mk(16'hFFFF, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            send_op(ta[i], tb[i], tm[i], te[i]);
            wait_out(lat);
            n_checks++;
            if (lat != LAT) begin n_fail++; $display("FAIL table%0d_latency: got %0d want %0d", i, lat, LAT); end
            e = sb.pop_front();
            n_checks++;
            if (result !== e.res) begin n_fail++; $display("FAIL table%0d_result: got %h want %h", i, result, e.res); end
            n_checks++;
            if (cout !== e.co) begin n_fail++; $display("FAIL table%0d_cout: got %b want %b", i, cout, e.co); end
            n_checks++;
            if (overflow !== e.ov) begin n_fail++; $display("FAIL table%0d_overflow: got %b want %b", i, overflow, e.ov); end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            n_checks++;
            if ({in_ready, out_valid} !== 2'b10) begin
                n_fail++;
                $display("FAIL table%0d_release: in_ready=%b out_valid=%b want 1 0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure;
        exp_t e;
        int   lat;
        send_op(16'h4000, 16'h4000, 1'b0, model(16'h4000, 16'h4000, 1'b0));
        wait_out(lat);
        n_checks++;
        if (lat != LAT) begin n_fail++; $display("FAIL bp_latency: got %0d want %0d", lat, LAT); end
        e = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; op_a = 16'h1111; op_b = 16'h2222; mode = 1'b1;
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, in_ready, busy, result, cout, overflow} !== {3'b101, e.res, e.co, e.ov}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: v=%b rdy=%b busy=%b res=%h c=%b o=%b want v=1 rdy=0 busy=1 res=%h c=%b o=%b",
                         i, out_valid, in_ready, busy, result, cout, overflow, e.res, e.co, e.ov);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL bp_release: v=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
        end
        n_checks++;
        if (result !== e.res) begin n_fail++; $display("FAIL bp_idle_hold: got %h want %h", result, e.res); end
    endtask

    task automatic test_reset_mid_run;
        exp_t e;
        int   lat;
        int   seen;
        send_op(16'hAAAA, 16'h5555, 1'b0, model(16'hAAAA, 16'h5555, 1'b0));
        sb.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({in_ready, out_valid, busy, result, cout, overflow} !== {3'b100, 16'h0000, 2'b00}) begin
            n_fail++;
            $display("FAIL midrun_reset: rdy=%b v=%b busy=%b res=%h c=%b o=%b want 1 0 0 0000 0 0",
                     in_ready, out_valid, busy, result, cout, overflow);
        end
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL midrun_no_output: out_valid cycles %0d want 0", seen); end
        send_op(16'h1234, 16'h1111, 1'b0, mk(16'h2345, 1'b0, 1'b0));
        wait_out(lat);
        n_checks++;
        if (lat != LAT) begin n_fail++; $display("FAIL after_reset_latency: got %0d want %0d", lat, LAT); end
        e = sb.pop_front();
        n_checks++;
        if ({result, cout, overflow} !== {e.res, e.co, e.ov}) begin
            n_fail++;
            $display("FAIL after_reset_result: got %h/%b/%b want %h/%b/%b", result, cout, overflow, e.res, e.co, e.ov);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [DATA_W-1:0] a, b;
        logic              m;
        exp_t              e;
        int                lat, t, t_prev;
        t_prev = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = DATA_W'($urandom); b = DATA_W'($urandom); m = 1'($urandom_range(0, 1));
            send_op(a, b, m, model(a, b, m));
            t = cyc;
            if (i > 0) begin
                n_checks++;
                if (t - t_prev != int'(LAT) + 2) begin
                    n_fail++;
                    $display("FAIL b2b_spacing%0d: got %0d want %0d", i, t - t_prev, LAT + 2);
                end
            end
            wait_out(lat);
            n_checks++;
            if (lat != LAT) begin n_fail++; $display("FAIL b2b_latency%0d: got %0d want %0d", i, lat, LAT); end
            e = sb.pop_front();
            n_checks++;
            if ({result, cout, overflow} !== {e.res, e.co, e.ov}) begin
                n_fail++;
                $display("FAIL b2b_result%0d: got %h/%b/%b want %h/%b/%b", i, result, cout, overflow, e.res, e.co, e.ov);
            end
            t_prev = t;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_random;
        logic [DATA_W-1:0] a, b;
        logic              m;
        exp_t              e;
        int                lat;
        for (int i = 0; i < 20; i++) begin
            a = DATA_W'($urandom); b = DATA_W'($urandom); m = 1'($urandom_range(0, 1));
            send_op(a, b, m, model(a, b, m));
            wait_out(lat);
            n_checks++;
            if (lat != LAT) begin n_fail++; $display("FAIL rand_latency%0d: got %0d want %0d", i, lat, LAT); end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            e = sb.pop_front();
            n_checks++;
            if ({out_valid, result, cout, overflow} !== {1'b1, e.res, e.co, e.ov}) begin
                n_fail++;
                $display("FAIL rand_result%0d: v=%b got %h/%b/%b want %h/%b/%b (a=%h b=%h m=%b)",
                         i, out_valid, result, cout, overflow, e.res, e.co, e.ov, a, b, m);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; mode = 1'b0; out_ready = 1'b0;
        test_reset();
        test_arith_table();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/addsub_nibble_sequencer.md
ADDSUB_NIBBLE_SEQUENCER -- requirements
Module: addsub_nibble_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning operand/result width in bits; legal values are multiples of 4 from 8 to 32.
REQ-002 The block SHALL have parameter NIB_W, default 4, meaning the slice width per cycle; it is fixed at 4.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, meaning reset; it is synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning an operand pair is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts operands this cycle.
REQ-007 The block SHALL have port op_a, input, DATA_W bits, meaning the minuend/addend.
REQ-008 The block SHALL have port op_b, input, DATA_W bits, meaning the subtrahend/addend.
REQ-009 The block SHALL have port mode, input, 1 bit, meaning 0 = add, 1 = subtract (A - B).
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning the result is held.
REQ-011 The block SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result.
REQ-012 The block SHALL have port result, output, DATA_W bits, meaning the sum or difference modulo 2^DATA_W.
REQ-013 The block SHALL have port cout, output, 1 bit, meaning the raw carry out of the MSB; in subtract mode 1 = no borrow.
REQ-014 The block SHALL have port overflow, output, 1 bit, meaning two's-complement signed overflow.
REQ-015 The block SHALL have port busy, output, 1 bit, meaning the FSM is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE; IDLE -> RUN on in_valid && in_ready; RUN -> DONE after the last slice; DONE -> IDLE on out_valid && out_ready.
REQ-017 in_ready SHALL be 1 only in IDLE; there is no overlap of a new accept with RUN or DONE.
REQ-018 On accept, the block SHALL register A = op_a, B' = op_b XOR {DATA_W{mode}}, carry = mode and slice index = 0; later changes on the input ports have no effect.
REQ-019 In RUN, on each cycle, slice k SHALL be computed as {c, s} = A[k] + B'[k] + carry, with s written to result slice k, carry <= c and k <= k + 1; slices run LSB first.
REQ-020 On the last slice, the block SHALL set cout to the final carry and overflow to (carry into bit DATA_W-1) XOR (carry out of bit DATA_W-1).
REQ-021 Latency SHALL be as follows: if accept happens at edge E0, out_valid = 1 after edge E0 + DATA_W/4 (4 edges at the default); throughput is 1 operation per DATA_W/4 + 2 cycles minimum.
REQ-022 In DONE, result, cout and overflow SHALL stay stable while out_ready = 0, for any number of cycles.
REQ-023 result SHALL hold its last value in IDLE and be updated only during RUN; slices not yet written in RUN show partial values and are invalid while out_valid = 0.
REQ-024 The slice index SHALL wrap only by returning to IDLE; it is never reused mid-operation.
REQ-025 If in_valid is asserted during RUN or DONE, the block SHALL ignore it; the operand stays pending at the source because in_ready = 0.

Reset
REQ-026 rst = 1 at an edge SHALL force IDLE, in_ready = 1, out_valid = 0, busy = 0, result = 0, cout = 0, overflow = 0, carry = 0 and index = 0.
REQ-027 Reset SHALL take priority over any handshake in the same cycle, and a reset mid-RUN or mid-DONE SHALL discard the operation with no output produced.

Structure
REQ-028 The state encoding (IDLE/RUN/DONE) and NIB_W SHALL live in the shared package addsub_pkg.
REQ-029 The 4-bit slice SHALL be a separate combinational sub-module, nibble_adder (a, b, cin -> sum, cout, c_msb_in), built as a carry-lookahead adder; it is instantiated once.

Verification
REQ-030 Bench case SHALL be: 0x0000 + 0x0001, mode 0 -> result 0x0001, cout 0, overflow 0, out_valid after 4 edges.
REQ-031 Bench case SHALL be: 0xFFFF - 0x0001, mode 1 -> result 0xFFFE, cout 1, overflow 0.
REQ-032 Bench case SHALL be: 0x7FFF + 0x0001 -> result 0x8000, cout 0, overflow 1; and 0x8000 - 0x0001 -> result 0x7FFF, cout 1, overflow 1.
REQ-033 Bench case SHALL be: 0x0000 - 0x0001 -> result 0xFFFF, cout 0, overflow 0.
REQ-034 Bench case SHALL be: out_ready held 0 for 3 cycles in DONE -> outputs unchanged and in_ready stays 0; handshake -> IDLE on the next edge.
REQ-035 Bench case SHALL be: rst pulsed after the 2nd RUN edge -> all outputs at reset values next cycle, no out_valid; a following 0x1234 + 0x1111 -> result 0x2345.
